// File: rtl/max_pool_stream_ctrl_if.sv
// Pixel-in / pooled-out valid-ready stream bundle for the pooling scheduler.
// master drives pixels and consumes results; slave is the pooling block.
interface max_pool_stream_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/max_pool_stream_ctrl.sv
// Streaming POOLxPOOL max-pool scheduler, one partial max per output column.
// Optional MAX_POOL_RELU_EN clamps negative results to zero (fused ReLU).
module max_pooling_unit #(
  parameter int SIZE    = 2,
  parameter int I_WIDTH = 8
) (
  input  logic [SIZE*I_WIDTH-1:0] in_data,
  output logic [I_WIDTH-1:0]      out_data
);
  logic [I_WIDTH-1:0] m;

  always_comb begin
    m = in_data[I_WIDTH-1:0];
    for (int i = 1; i < SIZE; i++) begin
      if ($signed(in_data[i*I_WIDTH +: I_WIDTH]) > $signed(m))
        m = in_data[i*I_WIDTH +: I_WIDTH];
    end
    out_data = m;
  end
endmodule

module max_pool_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int POOL       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  max_pool_stream_ctrl_if.slave bus,
  output logic                  done
);
  localparam int NW = IMG_WIDTH / POOL;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(POOL);
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, nstate;

  logic [KW-1:0] col_k;
  logic [PW-1:0] col_p;
  logic [PW-1:0] row_p;
  logic [RW-1:0] row;

  logic [DATA_WIDTH-1:0] part [NW];
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] mx;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] od;

  logic ov, ol, drain, rdy, acc;
  logic first, last, eol, eof;

  assign drain = !ov || bus.out_ready;
  assign rdy   = (state == RUN) && drain;
  assign acc   = bus.in_valid && rdy;

  assign first = (col_p == '0) && (row_p == '0);
  assign last  = (col_p == PW'(POOL-1)) && (row_p == PW'(POOL-1));
  assign eol   = (col_k == KW'(NW-1)) && (col_p == PW'(POOL-1));
  assign eof   = eol && (row == RW'(IMG_HEIGHT-1));

  assign cur = part[col_k];

  max_pooling_unit #(
    .SIZE    (2),
    .I_WIDTH (DATA_WIDTH)
  ) u_max (
    .in_data  ({bus.in_data, cur}),
    .out_data (mx)
  );

`ifdef MAX_POOL_RELU_EN
  assign res = mx[DATA_WIDTH-1] ? '0 : mx;
`else
  assign res = mx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (acc && eof) nstate = FLUSH;
      FLUSH:   if (drain) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_k <= '0;
      col_p <= '0;
      row_p <= '0;
      row   <= '0;
    end else if (state == IDLE && start) begin
      col_k <= '0;
      col_p <= '0;
      row_p <= '0;
      row   <= '0;
    end else if (acc) begin
      if (col_p == PW'(POOL-1)) begin
        col_p <= '0;
        if (col_k == KW'(NW-1)) begin
          col_k <= '0;
          row   <= (row == RW'(IMG_HEIGHT-1)) ? '0 : row + 1'b1;
          row_p <= (row_p == PW'(POOL-1)) ? '0 : row_p + 1'b1;
        end else begin
          col_k <= col_k + 1'b1;
        end
      end else begin
        col_p <= col_p + 1'b1;
      end
    end
  end

  // first pixel of a window overwrites, so no reset is needed here
  always_ff @(posedge clk) begin
    if (acc) part[col_k] <= first ? bus.in_data : mx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov   <= 1'b0;
      ol   <= 1'b0;
      od   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FLUSH) && drain;
      if (acc && last) begin
        od <= res;
        ov <= 1'b1;
        ol <= eof;
      end else if (drain) begin
        ov <= 1'b0;
        ol <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = od;
  assign bus.out_valid = ov;
  assign bus.out_last  = ol;
endmodule

// File: tb/tb_max_pool_stream_ctrl.sv
// Directed bench: 4x4/POOL=2 frame tables plus a 6x6/POOL=3 back-to-back pair.
// Expected values are hand-computed; ReLU variant applied when MAX_POOL_RELU_EN is set.
module tb_max_pool_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic start, start2;
  logic done, done2;

  always #5 clk = ~clk;

  max_pool_stream_ctrl_if #(.DATA_WIDTH(8)) bus ();
  max_pool_stream_ctrl_if #(.DATA_WIDTH(8)) bus2 ();

  max_pool_stream_ctrl #(
    .DATA_WIDTH (8), .IMG_WIDTH (4), .IMG_HEIGHT (4), .POOL (2)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .bus (bus), .done (done)
  );

  max_pool_stream_ctrl #(
    .DATA_WIDTH (8), .IMG_WIDTH (6), .IMG_HEIGHT (6), .POOL (3)
  ) dut2 (
    .clk (clk), .rst_n (rst_n), .start (start2), .bus (bus2), .done (done2)
  );

  typedef struct packed {
    logic [15:0][7:0] pix;
    logic [3:0][7:0]  exp;
  } vec_t;

  vec_t tbl [3];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic logic [7:0] rl(input logic [7:0] v);
`ifdef MAX_POOL_RELU_EN
    return v[7] ? 8'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // window w of a 4x4 frame covers indices base, base+1, base+4, base+5
  task automatic setw(input int t, input int w,
                      input int a, input int b, input int c, input int d,
                      input int e);
    int base;
    base = (w / 2) * 8 + (w % 2) * 2;
    tbl[t].pix[base]   = 8'(a);
    tbl[t].pix[base+1] = 8'(b);
    tbl[t].pix[base+4] = 8'(c);
    tbl[t].pix[base+5] = 8'(d);
    tbl[t].exp[w]      = 8'(e);
  endtask

  task automatic run_frame(input vec_t v, input bit stall, input bit spam);
    int idx, oidx, stl, sp, cyc, acc_cyc;
    bit fin;
    int lat [4];
    lat = '{6, 8, 14, 16};
    idx = 0; oidx = 0; stl = 0; sp = 0; cyc = 0; acc_cyc = 0; fin = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start        = spam && idx >= 7 && oidx < 4;
      bus.in_valid = (idx < 16);
      bus.in_data  = v.pix[(idx < 16) ? idx : 0];
      if (stall && bus.out_valid && oidx == 0 && stl < 5) begin
        bus.out_ready = 1'b0;
        stl++;
      end else if (spam && idx == 16 && sp < 2) begin
        bus.out_ready = 1'b0;
        sp++;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (done) begin
        fin = 1;
        chk("done_latency", cyc - acc_cyc, 1);
      end
      if (stall && bus.out_valid && !bus.out_ready && oidx == 0) begin
        chk("stall_hold", int'(bus.out_data), int'(rl(v.exp[0])));
        chk("stall_in_ready", int'(bus.in_ready), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (oidx < 4) begin
          chk("out_data", int'($signed(bus.out_data)),
              int'($signed(rl(v.exp[oidx]))));
          chk("out_last", int'(bus.out_last), int'(oidx == 3));
          if (!stall) chk("out_latency", idx, lat[oidx]);
        end else begin
          chk("extra_out", oidx + 1, 4);
        end
        oidx++;
        acc_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid  = 1'b0;
    start         = 1'b0;
    chk("done_seen", int'(fin), 1);
    chk("out_count", oidx, 4);
    chk("pix_count", idx, 16);
    @(negedge clk); #1;
    chk("done_pulse", int'(done), 0);
    chk("idle_in_ready", int'(bus.in_ready), 0);
    chk("idle_out_valid", int'(bus.out_valid), 0);
  endtask

  task automatic run2(input bit neg);
    int idx, oidx, cyc, ndone, pv;
    int exp [4];
    if (neg) exp = '{-1, -4, -19, -22};
    else     exp = '{14, 17, 32, 35};
    idx = 0; oidx = 0; cyc = 0; ndone = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (ndone == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      pv = neg ? -idx - 1 : idx;
      bus2.in_valid  = (idx < 36);
      bus2.in_data   = 8'(pv);
      bus2.out_ready = 1'b1;
      #1;
      if (done2) ndone++;
      if (bus2.out_valid && bus2.out_ready) begin
        if (oidx < 4)
          chk("p3_out_data", int'($signed(bus2.out_data)),
              int'($signed(rl(8'(exp[oidx])))));
        oidx++;
      end
      if (bus2.in_valid && bus2.in_ready) idx++;
    end
    bus2.in_valid = 1'b0;
    chk("p3_out_count", oidx, 4);
    chk("p3_done", ndone, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[0].pix[i] = 8'(i);
    tbl[0].exp = {8'd15, 8'd13, 8'd7, 8'd5};
    setw(1, 0, -3, -1, -7, -2, -1);
    setw(1, 1, -128, 127, 0, 5, 127);
    setw(1, 2, 10, 20, 30, -40, 30);
    setw(1, 3, -5, -6, -7, -8, -5);
    setw(2, 0, 7, 7, 7, 7, 7);
    setw(2, 1, -1, -1, -1, -1, -1);
    setw(2, 2, 0, -128, -128, -128, 0);
    setw(2, 3, 127, 127, -128, 127, 127);

    rst_n          = 1'b1;
    start          = 1'b0;
    start2         = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 3; t++) run_frame(tbl[t], 1'b0, 1'b0);
    run_frame(tbl[0], 1'b1, 1'b0);
    run_frame(tbl[1], 1'b0, 1'b1);

    // reset while the first result is held
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data  = tbl[0].pix[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_data", int'(bus.out_data), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(tbl[0], 1'b0, 1'b0);

    run2(1'b0);
    run2(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
